// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : fetch port, data port and memory bus of the arbiter
// Revision 1.0
// ============================================================================
interface mem_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_addr, d_we, d_wdata, d_wmask,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    // Requesters and memory side
    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_addr, d_we, d_wdata, d_wmask,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one single-port memory between fetch and data ports
// Revision 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LATENCY   = 1,
    parameter int MAX_CONSEC    = 4,
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int C_CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int C_CON_W = $clog2(MAX_CONSEC + 1);
    localparam logic [C_CNT_W-1:0] C_LAT_LOAD = C_CNT_W'(MEM_LATENCY - 1);
    localparam logic [C_CON_W-1:0] C_CON_MAX  = C_CON_W'(MAX_CONSEC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_CON_W-1:0]   consec_q, consec_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 owner_q, owner_d;   // 1 = data port owns the transaction
    logic [31:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wmask_q, wmask_d;

    logic w_pri_valid;
    logic w_oth_valid;
    logic w_contested;
    logic w_grant_pri;
    logic w_grant_oth;
    logic w_grant_d;
    logic w_grant_i;
    logic w_idle;
    logic w_resp;

    // The priority port yields only once it has won MAX_CONSEC contested rounds in a row
    assign w_pri_valid = DATA_PRIORITY ? bus.d_req_valid  : bus.if_req_valid;
    assign w_oth_valid = DATA_PRIORITY ? bus.if_req_valid : bus.d_req_valid;
    assign w_contested = w_pri_valid && w_oth_valid;
    assign w_grant_pri = w_pri_valid && (!w_oth_valid || (consec_q != C_CON_MAX));
    assign w_grant_oth = w_oth_valid && !w_grant_pri;
    assign w_grant_d   = DATA_PRIORITY ? w_grant_pri : w_grant_oth;
    assign w_grant_i   = DATA_PRIORITY ? w_grant_oth : w_grant_pri;

    assign w_idle = (state_q == S_IDLE);
    assign w_resp = (state_q == S_RESP);

    assign bus.if_req_ready = w_idle && w_grant_i;
    assign bus.d_req_ready  = w_idle && w_grant_d;

    assign bus.mem_en    = (state_q == S_ISSUE);
    assign bus.mem_we    = (state_q == S_ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;

    assign bus.if_rsp_valid = w_resp && !owner_q;
    assign bus.d_rsp_valid  = w_resp && owner_q;
    assign bus.if_rsp_data  = (w_resp && !owner_q)        ? bus.mem_rdata : 32'h0;
    assign bus.d_rsp_rdata  = (w_resp && owner_q && !we_q) ? bus.mem_rdata : 32'h0;

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_grant_d) begin
                    owner_d = 1'b1;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    wmask_d = bus.d_wmask;
                    state_d = S_ISSUE;
                end else if (w_grant_i) begin
                    // Fetches never write, so the strobes are cleared at latch time
                    owner_d = 1'b0;
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                    wmask_d = 4'h0;
                    state_d = S_ISSUE;
                end

                if (w_grant_pri && w_contested && (consec_q != C_CON_MAX)) begin
                    consec_d = consec_q + C_CON_W'(1);
                end else if (w_grant_oth) begin
                    consec_d = '0;
                end
            end

            S_ISSUE: begin
                cnt_d   = C_LAT_LOAD;
                state_d = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q - C_CNT_W'(1);
                if (cnt_q <= C_CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            consec_q <= '0;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            wmask_q  <= 4'h0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end
endmodule
`default_nettype wire
